// File: rtl/fpga_lut_pkg.sv
// Shared types and helpers for the K-input LUT logic element.
//   lut_cfg_state_e : configuration loader states
//   lut_mode_e      : output mode (combinational / registered)
//   cfg_len(k)      : configuration frame length (truth table + mode bit)
package fpga_lut_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } lut_cfg_state_e;

  typedef enum logic {
    MODE_COMB = 1'b0,
    MODE_REG  = 1'b1
  } lut_mode_e;

  // Frame length for a k-input LUT: 2**k truth-table bits plus the mode bit.
  function automatic int unsigned cfg_len(input int unsigned k);
    return (32'd1 << k) + 32'd1;
  endfunction

endpackage

// File: rtl/fpga_lut_cfg_loader.sv
// Serial, daisy-chainable configuration loader for one LUT cell.
//   clk, rst  : fabric clock, async active-high reset
//   start     : begin (or restart) a frame
//   valid     : bit_in is valid
//   bit_in    : serial configuration bit, MSB (mode bit) first
//   ready     : a bit is accepted this cycle
//   chain     : bit shifted out of the shadow MSB, feeds the next cell
//   done      : one-cycle pulse while the frame commits
//   shadow    : assembled frame {mode, tt[TT_W-1:0]}
//   commit_c  : strobe, active configuration is updated on this edge
module fpga_lut_cfg_loader
  import fpga_lut_pkg::*;
#(
  parameter  int unsigned K     = 4,
  localparam int unsigned CFG_N = cfg_len(K)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             valid,
  input  logic             bit_in,
  output logic             ready,
  output logic             chain,
  output logic             done,
  output logic [CFG_N-1:0] shadow,
  output logic             commit_c
);

  localparam int unsigned CNT_W = $clog2(CFG_N + 1);

  lut_cfg_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CFG_N-1:0] shadow_q, shadow_d;
  logic             chain_d;
  logic             ready_d;
  logic             done_d;

  // State, counter, shift register and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      chain    <= 1'b0;
      ready    <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      chain    <= chain_d;
      ready    <= ready_d;
      done     <= done_d;
    end
  end

  // Next-state logic; a start inside LOAD restarts the count but keeps the shadow.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    chain_d  = chain;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (start) begin
          cnt_d = '0;
        end else if (valid && ready) begin
          shadow_d = {shadow_q[CFG_N-2:0], bit_in};
          chain_d  = shadow_q[CFG_N-1];
          if (cnt_q != CNT_W'(CFG_N)) cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(CFG_N - 1)) state_d = COMMIT;
        end
      end
      COMMIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ready_d = (state_d == LOAD);
    done_d  = (state_d == COMMIT);
  end

  assign shadow   = shadow_q;
  assign commit_c = (state_q == COMMIT);

endmodule

// File: rtl/fpga_klut.sv
// K-input LUT logic element with double-buffered truth table and optional
// registered output.
//   clk_i, rst_i   : fabric clock, async active-high reset
//   cfg_start_i    : begin a configuration frame
//   cfg_valid_i    : cfg_bit_i is valid
//   cfg_bit_i      : serial configuration bit (mode bit first, then tt MSB..LSB)
//   cfg_ready_o    : loader accepts a bit this cycle
//   cfg_chain_o    : serial output to the next cell's cfg_bit_i
//   cfg_done_o     : one-cycle pulse on commit
//   cfg_loaded_o   : a configuration has been committed since reset
//   in_i           : LUT select inputs
//   ce_i           : output register clock enable
//   out_o          : LUT output (combinational or registered per mode bit)
module fpga_klut
  import fpga_lut_pkg::*;
#(
  parameter int unsigned K     = 4,
  parameter int unsigned TT_W  = 2**K,
  parameter int unsigned CFG_N = TT_W + 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cfg_start_i,
  input  logic         cfg_valid_i,
  input  logic         cfg_bit_i,
  output logic         cfg_ready_o,
  output logic         cfg_chain_o,
  output logic         cfg_done_o,
  output logic         cfg_loaded_o,
  input  logic [K-1:0] in_i,
  input  logic         ce_i,
  output logic         out_o
);

  if (K < 2 || K > 6) begin : g_bad_k
    $error("fpga_klut: K must be in 2..6");
  end

  logic [CFG_N-1:0] shadow;
  logic             commit_c;
  logic [TT_W-1:0]  active_tt;
  lut_mode_e        active_mode;
  logic             ff_q;
  logic             loaded_q;
  logic             f_c;

  fpga_lut_cfg_loader #(.K(K)) u_loader (
    .clk      (clk_i),
    .rst      (rst_i),
    .start    (cfg_start_i),
    .valid    (cfg_valid_i),
    .bit_in   (cfg_bit_i),
    .ready    (cfg_ready_o),
    .chain    (cfg_chain_o),
    .done     (cfg_done_o),
    .shadow   (shadow),
    .commit_c (commit_c)
  );

  assign f_c = active_tt[in_i];

  // Active configuration and output register; a commit clears the output FF.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      active_tt   <= '0;
      active_mode <= MODE_COMB;
      ff_q        <= 1'b0;
      loaded_q    <= 1'b0;
    end else if (commit_c) begin
      active_tt   <= shadow[TT_W-1:0];
      active_mode <= lut_mode_e'(shadow[CFG_N-1]);
      ff_q        <= 1'b0;
      loaded_q    <= 1'b1;
    end else if (ce_i) begin
      ff_q        <= f_c;
    end
  end

  assign out_o        = (active_mode == MODE_REG) ? ff_q : f_c;
  assign cfg_loaded_o = loaded_q;

endmodule

// File: tb/tb_fpga_klut.sv
// Self-checking bench for fpga_klut: K=4 chained pair plus K=2 and K=6 cells,
// checked against a behavioural model of the active configuration.
module tb_fpga_klut;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start [4];
  logic valid [4];
  logic bit_v [4];
  logic ce    [4];
  logic [5:0] in_v [4];
  logic ready [4];
  logic chain [4];
  logic done  [4];
  logic loaded[4];
  logic out   [4];
  logic b_valid_q = 1'b0;

  int kk [4] = '{4, 4, 2, 6};

  // Behavioural model of each cell's committed state.
  logic [63:0] tt_m   [4];
  logic        mode_m [4];
  logic        ff_m   [4];
  logic        ld_m   [4];
  bit          hist   [4][$];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Downstream cell sees the upstream chain bit one cycle after each accept.
  always @(posedge clk) b_valid_q <= valid[0] & ready[0];

  fpga_klut #(.K(4)) u_a (
    .clk_i(clk), .rst_i(rst), .cfg_start_i(start[0]), .cfg_valid_i(valid[0]),
    .cfg_bit_i(bit_v[0]), .cfg_ready_o(ready[0]), .cfg_chain_o(chain[0]),
    .cfg_done_o(done[0]), .cfg_loaded_o(loaded[0]), .in_i(in_v[0][3:0]),
    .ce_i(ce[0]), .out_o(out[0]));

  fpga_klut #(.K(4)) u_b (
    .clk_i(clk), .rst_i(rst), .cfg_start_i(start[1]), .cfg_valid_i(b_valid_q),
    .cfg_bit_i(chain[0]), .cfg_ready_o(ready[1]), .cfg_chain_o(chain[1]),
    .cfg_done_o(done[1]), .cfg_loaded_o(loaded[1]), .in_i(in_v[1][3:0]),
    .ce_i(ce[1]), .out_o(out[1]));

  fpga_klut #(.K(2)) u_k2 (
    .clk_i(clk), .rst_i(rst), .cfg_start_i(start[2]), .cfg_valid_i(valid[2]),
    .cfg_bit_i(bit_v[2]), .cfg_ready_o(ready[2]), .cfg_chain_o(chain[2]),
    .cfg_done_o(done[2]), .cfg_loaded_o(loaded[2]), .in_i(in_v[2][1:0]),
    .ce_i(ce[2]), .out_o(out[2]));

  fpga_klut #(.K(6)) u_k6 (
    .clk_i(clk), .rst_i(rst), .cfg_start_i(start[3]), .cfg_valid_i(valid[3]),
    .cfg_bit_i(bit_v[3]), .cfg_ready_o(ready[3]), .cfg_chain_o(chain[3]),
    .cfg_done_o(done[3]), .cfg_loaded_o(loaded[3]), .in_i(in_v[3]),
    .ce_i(ce[3]), .out_o(out[3]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int frame_len(input int idx);
    return (1 << kk[idx]) + 1;
  endfunction

  function automatic logic [63:0] tt_mask(input int idx);
    if (kk[idx] == 6) return '1;
    return (64'd1 << (1 << kk[idx])) - 64'd1;
  endfunction

  function automatic logic exp_out(input int idx);
    return mode_m[idx] ? ff_m[idx] : tt_m[idx][in_v[idx]];
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 4; i++) begin
      tt_m[i] = '0; mode_m[i] = 1'b0; ff_m[i] = 1'b0; ld_m[i] = 1'b0;
      hist[i].delete();
      for (int j = 0; j < frame_len(i); j++) hist[i].push_back(1'b0);
    end
  endtask

  // Advance one clock; output FFs follow the enabled LUT value.
  task automatic tick();
    for (int i = 0; i < 4; i++)
      if (!rst && ce[i]) ff_m[i] = tt_m[i][in_v[i]];
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_bit(input int idx, input bit b);
    bit exp_chain;
    valid[idx] = 1'b1;
    bit_v[idx] = b;
    #1;
    check($sformatf("done_early[%0d]", idx), 64'(done[idx]), 64'd0);
    check($sformatf("ready_load[%0d]", idx), 64'(ready[idx]), 64'd1);
    check($sformatf("out_old[%0d]", idx), 64'(out[idx]), 64'(exp_out(idx)));
    tick();
    exp_chain = hist[idx].pop_front();
    hist[idx].push_back(b);
    check($sformatf("chain[%0d]", idx), 64'(chain[idx]), 64'(exp_chain));
  endtask

  task automatic partial(input int idx, input int nb);
    start[idx] = 1'b1;
    tick();
    start[idx] = 1'b0;
    for (int i = 0; i < nb; i++) send_bit(idx, 1'($urandom_range(0, 1)));
    valid[idx] = 1'b0;
  endtask

  task automatic load_frame(input int idx, input bit mode, input logic [63:0] tt, input bit with_b);
    int n;
    bit b;
    n = frame_len(idx);
    valid[idx] = 1'b0;
    start[idx] = 1'b1;
    if (with_b) start[1] = 1'b1;
    tick();
    start[idx] = 1'b0;
    start[1] = 1'b0;
    for (int i = 0; i < n; i++) begin
      b = (i == 0) ? mode : tt[n - 1 - i];
      send_bit(idx, b);
    end
    valid[idx] = 1'b0;
    #1;
    check($sformatf("done_pulse[%0d]", idx), 64'(done[idx]), 64'd1);
    check($sformatf("ready_commit[%0d]", idx), 64'(ready[idx]), 64'd0);
    check($sformatf("out_commit[%0d]", idx), 64'(out[idx]), 64'(exp_out(idx)));
    tick();
    tt_m[idx] = tt & tt_mask(idx);
    mode_m[idx] = mode;
    ff_m[idx] = 1'b0;
    ld_m[idx] = 1'b1;
    check($sformatf("done_end[%0d]", idx), 64'(done[idx]), 64'd0);
    check($sformatf("loaded[%0d]", idx), 64'(loaded[idx]), 64'(ld_m[idx]));
    check($sformatf("out_new[%0d]", idx), 64'(out[idx]), 64'(exp_out(idx)));
  endtask

  task automatic sweep(input int idx);
    for (int a = 0; a < (1 << kk[idx]); a++) begin
      in_v[idx] = 6'(a);
      #1;
      check($sformatf("sweep[%0d] a=%0d", idx, a), 64'(out[idx]), 64'(exp_out(idx)));
      tick();
    end
  endtask

  task automatic check_in(input int idx, input int a, input logic exp);
    in_v[idx] = 6'(a);
    #1;
    check($sformatf("lut[%0d] in=%0h", idx, a), 64'(out[idx]), 64'(exp));
    tick();
  endtask

  initial begin
    int ids[3] = '{0, 2, 3};
    logic [63:0] r;
    bit m;
    for (int i = 0; i < 4; i++) begin
      start[i] = 0; valid[i] = 0; bit_v[i] = 0; ce[i] = 0; in_v[i] = '0;
    end
    reset_model();
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_ready[%0d]", i), 64'(ready[i]), 64'd0);
      check($sformatf("rst_chain[%0d]", i), 64'(chain[i]), 64'd0);
      check($sformatf("rst_done[%0d]", i), 64'(done[i]), 64'd0);
      check($sformatf("rst_loaded[%0d]", i), 64'(loaded[i]), 64'd0);
      check($sformatf("rst_out[%0d]", i), 64'(out[i]), 64'd0);
    end
    rst = 1'b0;
    tick();

    // Idle: valid pulses are ignored, outputs stay at reset values.
    for (int c = 0; c < 6; c++) begin
      valid[0] = c[0]; bit_v[0] = 1'b1; in_v[0] = 6'($urandom_range(0, 15));
      tick();
      check("idle_chain", 64'(chain[0]), 64'd0);
      check("idle_ready", 64'(ready[0]), 64'd0);
      check("idle_out", 64'(out[0]), 64'd0);
      check("idle_loaded", 64'(loaded[0]), 64'd0);
    end
    valid[0] = 1'b0;

    // Mode 0 with 16'h00F0.
    load_frame(0, 1'b0, 64'h00F0, 1'b0);
    check_in(0, 4'h4, 1'b1);
    check_in(0, 4'h3, 1'b0);
    check_in(0, 4'hF, 1'b0);
    sweep(0);

    // Mode 1 with 16'h8000: one-edge latency, hold with ce low.
    load_frame(0, 1'b1, 64'h8000, 1'b0);
    in_v[0] = 6'hF; ce[0] = 1'b1;
    #1;
    check("reg_before_edge", 64'(out[0]), 64'd0);
    tick();
    check("reg_after_edge", 64'(out[0]), 64'd1);
    ce[0] = 1'b0; in_v[0] = 6'h0;
    tick();
    check("reg_hold", 64'(out[0]), 64'd1);
    tick();
    check("reg_hold2", 64'(out[0]), 64'(exp_out(0)));

    // Abort after 8 bits, then a full all-ones frame.
    partial(0, 8);
    load_frame(0, 1'b0, 64'hFFFF, 1'b0);
    sweep(0);

    // Reset in the middle of a frame.
    partial(0, 5);
    rst = 1'b1;
    #1;
    reset_model();
    check("midrst_ready", 64'(ready[0]), 64'd0);
    check("midrst_loaded", 64'(loaded[0]), 64'd0);
    check("midrst_out", 64'(out[0]), 64'd0);
    check("midrst_chain", 64'(chain[0]), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    sweep(0);

    // Daisy chain: first frame ends up downstream, second stays upstream.
    r = 64'($urandom_range(0, 16'hFFFF));
    m = 1'($urandom_range(0, 1));
    load_frame(0, m, r, 1'b0);
    load_frame(0, 1'b0, 64'($urandom_range(0, 16'hFFFF)), 1'b1);
    check("chain_b_done", 64'(done[1]), 64'd1);
    tick();
    tt_m[1] = r & 64'hFFFF; mode_m[1] = m; ff_m[1] = 1'b0; ld_m[1] = 1'b1;
    check("chain_b_done_end", 64'(done[1]), 64'd0);
    check("chain_b_loaded", 64'(loaded[1]), 64'd1);
    sweep(1);
    sweep(0);

    // Walking-one sweeps on K=2 and K=6.
    for (int s = 2; s < 4; s++)
      for (int j = 0; j < (1 << kk[s]); j++) begin
        load_frame(s, 1'b0, 64'd1 << j, 1'b0);
        for (int a = 0; a < (1 << kk[s]); a++) begin
          in_v[s] = 6'(a);
          #1;
          check($sformatf("walk K=%0d j=%0d a=%0d", kk[s], j, a), 64'(out[s]), 64'(a == j));
          tick();
        end
      end

    // Random configurations and random in/ce traffic.
    for (int it = 0; it < 8; it++)
      foreach (ids[n]) begin
        r = {32'($urandom), 32'($urandom)};
        load_frame(ids[n], 1'($urandom_range(0, 1)), r, 1'b0);
        for (int c = 0; c < 20; c++) begin
          in_v[ids[n]] = 6'($urandom) & 6'(tt_mask(ids[n]) == '1 ? 63 : (1 << kk[ids[n]]) - 1);
          ce[ids[n]] = 1'($urandom_range(0, 1));
          #1;
          check($sformatf("rnd_pre[%0d]", ids[n]), 64'(out[ids[n]]), 64'(exp_out(ids[n])));
          tick();
          check($sformatf("rnd_post[%0d]", ids[n]), 64'(out[ids[n]]), 64'(exp_out(ids[n])));
        end
        ce[ids[n]] = 1'b0;
      end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
